// File: rtl/key_evt_pkg.sv
// Shared types and constants for the key event arbiter.
//   evt_t  : one queued event (key index + long/short flag)
//   KEY_W  : key index field width, sized for the largest supported key count (8)
//   DROP_W : width of the saturating lost-event counter
package key_evt_pkg;

  localparam int KEY_W  = 3;
  localparam int DROP_W = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic             long_evt;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

endpackage

// File: rtl/key_evt_fifo.sv
// Show-ahead synchronous FIFO for key events.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full)
//   pop        : read request (ignored when empty)
//   dout       : head entry, valid whenever empty is low
//   full, empty, level : occupancy status, level in 0..DEPTH
module key_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_L = (PW+1)'(DEPTH);
  localparam logic [PW:0]   ONE_L   = (PW+1)'(1);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   level_q;
  logic          do_push, do_pop;

  assign full    = (level_q == DEPTH_L);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage has no reset; the pointers and level define which entries
  // are meaningful, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (do_push) wr_ptr_q <= wr_ptr_q + ONE_P;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ONE_P;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + ONE_L;
        2'b01:   level_q <= level_q - ONE_L;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Collects per-key short/long press pulses into sticky pending flags,
// arbitrates them round-robin into an event FIFO (long before short within
// a key) and counts events lost because their flag was already pending.
//   clk, rst_n            : clock, asynchronous active-low reset
//   key_first, key_long   : per-key one-cycle press pulses
//   evt_valid, evt_ready  : head-of-FIFO handshake
//   evt_key, evt_long     : head event (zero while evt_valid is low)
//   fifo_level            : FIFO occupancy
//   drop_cnt, clr_drop    : saturating lost-event count and its clear
module key_event_arbiter
  import key_evt_pkg::*;
#(
  parameter int N_KEYS     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_KEYS-1:0]             key_first,
  input  logic [N_KEYS-1:0]             key_long,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(N_KEYS)-1:0]     evt_key,
  output logic                          evt_long,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]             drop_cnt,
  input  logic                          clr_drop
);

  localparam int IW = $clog2(N_KEYS);
  localparam logic [IW-1:0] LAST_KEY = IW'(N_KEYS - 1);
  localparam logic [IW-1:0] ONE_K    = IW'(1);

  logic [N_KEYS-1:0] pend_s_q, pend_s_d, pend_l_q, pend_l_d;
  logic [N_KEYS-1:0] gnt_s, gnt_l, drop_s, drop_l;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d, gnt_idx;
  logic              gnt_vld, fifo_full, fifo_empty;
  logic [4:0]        n_drop;
  logic [DROP_W:0]   drop_sum;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  evt_t              push_evt, head_evt;

  // Round-robin search starting at rr_ptr; no grant while the FIFO is full,
  // even if it pops this cycle.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin : arb
    int cand;
    cand    = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_s   = '0;
    gnt_l   = '0;
    if (!fifo_full) begin
      for (int i = 0; i < N_KEYS; i++) begin
        cand = (int'(rr_ptr_q) + i) % N_KEYS;
        if (!gnt_vld && (pend_s_q[cand] || pend_l_q[cand])) begin
          gnt_vld = 1'b1;
          gnt_idx = IW'(cand);
        end
      end
    end
    if (gnt_vld) begin
      if (pend_l_q[gnt_idx]) gnt_l[gnt_idx] = 1'b1;
      else                   gnt_s[gnt_idx] = 1'b1;
    end
  end

  assign rr_ptr_d = !gnt_vld               ? rr_ptr_q :
                    (gnt_idx == LAST_KEY)  ? '0       : gnt_idx + ONE_K;

  assign push_evt.key      = KEY_W'(gnt_idx);
  assign push_evt.long_evt = |gnt_l;

  // A pulse on the grant cycle re-arms the flag; a pulse onto a flag that
  // stays set is lost.
  assign pend_s_d = key_first | (pend_s_q & ~gnt_s);
  assign pend_l_d = key_long  | (pend_l_q & ~gnt_l);
  assign drop_s   = key_first & pend_s_q & ~gnt_s;
  assign drop_l   = key_long  & pend_l_q & ~gnt_l;

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      n_drop = n_drop + 5'(drop_s[i]) + 5'(drop_l[i]);
    end
    drop_sum = (DROP_W+1)'(drop_cnt_q) + (DROP_W+1)'(n_drop);
    if (clr_drop)              drop_cnt_d = '0;
    else if (drop_sum[DROP_W]) drop_cnt_d = '1;
    else                       drop_cnt_d = drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_s_q   <= '0;
      pend_l_q   <= '0;
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      pend_s_q   <= pend_s_d;
      pend_l_q   <= pend_l_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (gnt_vld),
    .din   (push_evt),
    .pop   (evt_valid && evt_ready),
    .dout  (head_evt),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Head fields are masked while empty so reset shows zeros, not stale data.
  assign evt_valid = !fifo_empty;
  assign evt_key   = evt_valid ? IW'(head_evt.key) : '0;
  assign evt_long  = evt_valid && head_evt.long_evt;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/key_event_arbiter.md
KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, number of key-event sources (2..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port key_first  input  N_KEYS  per-key short-press pulse, one cycle wide.
REQ-006 SHALL have port key_long  input  N_KEYS  per-key long-press pulse, one cycle wide.
REQ-007 SHALL have port evt_valid  output  1  event available at head of FIFO.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts head event.
REQ-009 SHALL have port evt_key  output  $clog2(N_KEYS)  key index of head event.
REQ-010 SHALL have port evt_long  output  1  head event type: 1 = long, 0 = short.
REQ-011 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port drop_cnt  output  8  count of lost events, saturating.
REQ-013 SHALL have port clr_drop  input  1  synchronous clear of drop_cnt.

Function
REQ-014 SHALL hold two sticky flags per key, pend_s[i] and pend_l[i]; a key_first[i] or key_long[i] pulse sets the corresponding flag at the next clock edge.
REQ-015 SHALL clear a pending flag only on the cycle it is granted into the FIFO.
REQ-016 SHALL keep the flag set when a pulse arrives on the same cycle the flag is granted, so the new event stays pending.
REQ-017 SHALL drop a pulse that arrives while its flag is already set and not granted that cycle, and SHALL increment drop_cnt by 1, saturating at 255.
REQ-018 SHALL count both drops when short and long pulses are dropped on the same cycle: +2, saturating.
REQ-019 SHALL give clr_drop priority over increments; drop_cnt is 0 after the edge.
REQ-020 SHALL grant at most one event per cycle, and only when the FIFO is not full (full flag only; no same-cycle pop credit).
REQ-021 SHALL select the requesting key by round-robin starting at rr_ptr, where a key requests if pend_s or pend_l is set.
REQ-022 SHALL, within the granted key, take long before short; the remaining flag is served on that key's next turn.
REQ-023 SHALL set rr_ptr to (granted index + 1) mod N_KEYS after each grant, and leave it unchanged when there is no grant.
REQ-024 SHALL use a fixed latency: pulse at edge k, pending after k, FIFO write at edge k+1, evt_valid high after k+1 when the FIFO was empty.
REQ-025 SHALL present the FIFO head show-ahead; evt_key and evt_long are stable while evt_valid=1 and evt_ready=0.
REQ-026 SHALL pop on evt_valid && evt_ready; a push and pop on the same cycle leave fifo_level unchanged.
REQ-027 SHALL report fifo_level exactly, in 0..FIFO_DEPTH; the pointers wrap modulo FIFO_DEPTH.
REQ-028 SHALL ignore evt_ready while evt_valid=0.

Reset
REQ-029 SHALL, on rst_n low asserted at any time, clear all pending flags, rr_ptr, FIFO pointers and drop_cnt to 0, and force evt_valid to 0.
REQ-030 SHALL hold evt_key=0, evt_long=0 and fifo_level=0 during reset.
REQ-031 SHALL ignore pulses in the cycle rst_n deasserts if that cycle coincides with the release edge; the first honoured pulse is at the first edge with rst_n high.
REQ-032 SHALL lose all FIFO contents and pending events on a mid-operation reset, without incrementing drop_cnt.

Structure
REQ-033 SHALL define package key_evt_pkg containing typedef evt_t {key index, long bit} and the drop counter width constant.
REQ-034 SHALL implement the FIFO as sub-module key_evt_fifo (parameter DEPTH, width of evt_t, push, pop, full, empty, level).
REQ-035 SHALL keep the arbiter, pending flags and drop counter in key_event_arbiter.

Verification
REQ-036 Single event: key_first[2] pulse at edge 10 -> evt_valid=1 after edge 11, evt_key=2, evt_long=0, fifo_level=1; evt_ready=1 -> level 0.
REQ-037 Fairness: all four key_first bits pulse together, evt_ready=1 -> keys output in order 0,1,2,3, one per cycle; rr_ptr ends at 0.
REQ-038 Long priority: key_first[1] and key_long[1] on the same cycle -> events (1,long) then (1,short), with no other requester.
REQ-039 Backpressure: evt_ready=0, 6 distinct events with DEPTH=4 -> fifo_level=4, 2 events stay pending; releasing evt_ready delivers all 6 with drop_cnt=0.
REQ-040 Drop: FIFO full, key_first[0] pulsed 3 times -> 1 event pending, drop_cnt=2; clr_drop -> 0; 300 drops -> 255.
REQ-041 Reset mid-run: fifo_level=3, rst_n low for 1 cycle -> evt_valid=0, fifo_level=0, drop_cnt=0; the next pulse gives normal 2-cycle latency.
